ama_riscv_hpm: RTL and testbench

AMA_RISCV_HPM -- requirements
Module: ama_riscv_hpm

---
 rtl/ama_riscv_hpm_pkg.sv | 37 +++
 rtl/ama_riscv_hpm_cnt.sv | 104 ++++++++++
 rtl/ama_riscv_hpm.sv | 108 ++++++++++
 tb/tb_ama_riscv_hpm.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_hpm_pkg.sv
// Shared constants and types for the hardware performance monitor: CSR addresses,
// mhpmevent field positions and the event-register view.
package ama_riscv_hpm_pkg;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;

  // Architectural slots per window: counters 3..31
  localparam int HPM_SLOTS = 29;

  localparam int EVT_SEL_LSB = 0;
  localparam int EVT_SEL_W   = 8;
  localparam int EVT_OF_BIT  = 31;

  typedef struct packed {
    logic                 of;
    logic [EVT_SEL_W-1:0] sel;
  } hpm_evt_t;

  function automatic logic [31:0] evt_to_csr(input hpm_evt_t e);
    logic [31:0] r;
    r = '0;
    r[EVT_SEL_LSB +: EVT_SEL_W] = e.sel;
    r[EVT_OF_BIT]               = e.of;
    return r;
  endfunction

  function automatic hpm_evt_t csr_to_evt(input logic [31:0] d);
    hpm_evt_t e;
    e.sel = d[EVT_SEL_LSB +: EVT_SEL_W];
    e.of  = d[EVT_OF_BIT];
    return e;
  endfunction

endpackage

// File: rtl/ama_riscv_hpm_cnt.sv
// One programmable counter with its mhpmevent register (SEL, optional OF).
// OF storage exists only when AMA_RISCV_HPM_OVF_IRQ_EN is defined.
module ama_riscv_hpm_cnt
  import ama_riscv_hpm_pkg::*;
#(
  parameter int CNT_WIDTH = 64,
  parameter int NUM_EVT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_EVT-1:0]   i_evt,
  input  logic                 i_inhibit,
  input  logic                 i_we_evt,
  input  logic                 i_we_lo,
  input  logic                 i_we_hi,
  input  logic [31:0]          i_wdata,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic [31:0]          o_evt_rdata,
  output logic                 o_of
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_lo_wr;
  logic [CNT_WIDTH-1:0] w_cnt_hi_wr;
  logic [EVT_SEL_W-1:0] r_sel;
  logic                 w_evt_sel;
  logic                 w_hi_wr;
  logic                 w_wr;
  logic                 w_inc;
  logic                 w_wrap;
  hpm_evt_t             w_wr_evt;

  assign w_wr_evt = csr_to_evt(i_wdata);

  // SEL values of 0 or above NUM_EVT match no input and never count
  always_comb begin
    w_evt_sel = 1'b0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (r_sel == EVT_SEL_W'(i + 1)) w_evt_sel = i_evt[i];
    end
  end

  if (CNT_WIDTH > 32) begin : g_hi
    assign w_hi_wr     = i_we_hi;
    assign w_cnt_lo_wr = {r_cnt[CNT_WIDTH-1:32], i_wdata};
    assign w_cnt_hi_wr = {i_wdata[CNT_WIDTH-33:0], r_cnt[31:0]};
  end else begin : g_no_hi
    logic w_unused_hi;
    assign w_unused_hi = i_we_hi;
    assign w_hi_wr     = 1'b0;
    assign w_cnt_lo_wr = i_wdata;
    assign w_cnt_hi_wr = r_cnt;
  end

  // A software write to either half swallows a coincident increment
  assign w_wr   = i_we_lo | w_hi_wr;
  assign w_inc  = w_evt_sel & ~i_inhibit & ~w_wr;
  assign w_wrap = w_inc & (&r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_we_lo) begin
      r_cnt <= w_cnt_lo_wr;
    end else if (w_hi_wr) begin
      r_cnt <= w_cnt_hi_wr;
    end else if (w_inc) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= '0;
    end else if (i_we_evt) begin
      r_sel <= w_wr_evt.sel;
    end
  end

`ifdef AMA_RISCV_HPM_OVF_IRQ_EN
  logic r_of;

  // Hardware set on wrap beats a software clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_of <= 1'b0;
    end else if (w_wrap) begin
      r_of <= 1'b1;
    end else if (i_we_evt) begin
      r_of <= w_wr_evt.of;
    end
  end

  assign o_of = r_of;
`else
  logic w_unused_of;
  assign w_unused_of = w_wrap ^ w_wr_evt.of;
  assign o_of        = 1'b0;
`endif

  assign o_cnt       = r_cnt;
  assign o_evt_rdata = evt_to_csr(hpm_evt_t'{of: o_of, sel: r_sel});

endmodule

// File: rtl/ama_riscv_hpm.sv
// Hardware performance monitor: CSR decode, mcountinhibit, read mux and overflow IRQ.
// Overflow flags and ovf_irq are present only with AMA_RISCV_HPM_OVF_IRQ_EN defined.
module ama_riscv_hpm
  import ama_riscv_hpm_pkg::*;
#(
  parameter int NUM_CNT   = 6,
  parameter int CNT_WIDTH = 64,
  parameter int NUM_EVT   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        csr_addr,
  input  logic               csr_re,
  input  logic               csr_we,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_hit,
  input  logic [NUM_EVT-1:0] evt,
  output logic               ovf_irq
);

  localparam logic [11:0] CNT_WIN_SPAN = CSR_MHPMCOUNTER3H + 12'(HPM_SLOTS - 1) - CSR_MHPMCOUNTER3;

  logic [11:0]          w_evt_off;
  logic [11:0]          w_lo_off;
  logic [11:0]          w_hi_off;
  logic [11:0]          w_win_off;
  logic                 w_is_inh;
  logic                 w_in_evt;
  logic                 w_in_lo;
  logic                 w_in_hi;
  logic                 w_in_cnt_win;
  logic [NUM_CNT-1:0]   r_inhibit;
  logic [CNT_WIDTH-1:0] w_cnt      [NUM_CNT];
  logic [31:0]          w_evt_rd   [NUM_CNT];
  logic [31:0]          w_cnt_hi   [NUM_CNT];
  logic [31:0]          w_rd_term  [NUM_CNT];
  logic [NUM_CNT-1:0]   w_of;
  logic [31:0]          w_rdata;

  // Offsets below a window base wrap to large values, so one compare bounds each window
  assign w_evt_off    = csr_addr - CSR_MHPMEVENT3;
  assign w_lo_off     = csr_addr - CSR_MHPMCOUNTER3;
  assign w_hi_off     = csr_addr - CSR_MHPMCOUNTER3H;
  assign w_win_off    = csr_addr - CSR_MHPMCOUNTER3;
  assign w_is_inh     = (csr_addr == CSR_MCOUNTINHIBIT);
  assign w_in_evt     = (w_evt_off < 12'(HPM_SLOTS));
  assign w_in_lo      = (w_lo_off < 12'(HPM_SLOTS));
  assign w_in_hi      = (w_hi_off < 12'(HPM_SLOTS));
  assign w_in_cnt_win = (w_win_off <= CNT_WIN_SPAN);
  assign csr_hit      = w_is_inh | w_in_evt | w_in_cnt_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inhibit <= '0;
    end else if (csr_we && w_is_inh) begin
      r_inhibit <= csr_wdata[3 +: NUM_CNT];
    end
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    logic w_sel_evt;
    logic w_sel_lo;
    logic w_sel_hi;

    assign w_sel_evt = w_in_evt && (w_evt_off == 12'(k));
    assign w_sel_lo  = w_in_lo && (w_lo_off == 12'(k));
    assign w_sel_hi  = w_in_hi && (w_hi_off == 12'(k));

    ama_riscv_hpm_cnt #(
      .CNT_WIDTH (CNT_WIDTH),
      .NUM_EVT   (NUM_EVT)
    ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_evt       (evt),
      .i_inhibit   (r_inhibit[k]),
      .i_we_evt    (csr_we & w_sel_evt),
      .i_we_lo     (csr_we & w_sel_lo),
      .i_we_hi     (csr_we & w_sel_hi),
      .i_wdata     (csr_wdata),
      .o_cnt       (w_cnt[k]),
      .o_evt_rdata (w_evt_rd[k]),
      .o_of        (w_of[k])
    );

    if (CNT_WIDTH > 32) begin : g_h
      assign w_cnt_hi[k] = 32'(w_cnt[k][CNT_WIDTH-1:32]);
    end else begin : g_nh
      assign w_cnt_hi[k] = '0;
    end

    assign w_rd_term[k] = ({32{w_sel_evt}} & w_evt_rd[k])
                        | ({32{w_sel_lo}}  & w_cnt[k][31:0])
                        | ({32{w_sel_hi}}  & w_cnt_hi[k]);
  end

  always_comb begin
    w_rdata = {32{w_is_inh}} & 32'({r_inhibit, 3'b000});
    for (int k = 0; k < NUM_CNT; k++) begin
      w_rdata = w_rdata | w_rd_term[k];
    end
  end

  assign csr_rdata = csr_re ? w_rdata : 32'h0;
  assign ovf_irq   = |w_of;

endmodule

// File: tb/tb_ama_riscv_hpm.sv
// Directed bench for ama_riscv_hpm: a 64-bit/6-counter instance and a 32-bit/2-counter
// instance share all inputs; OF expectations follow AMA_RISCV_HPM_OVF_IRQ_EN.
module tb_ama_riscv_hpm;

`ifdef AMA_RISCV_HPM_OVF_IRQ_EN
  localparam bit OF_EN = 1'b1;
`else
  localparam bit OF_EN = 1'b0;
`endif

  localparam logic [31:0] EVT3_WRAPPED = OF_EN ? 32'h8000_0001 : 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_addr = '0;
  logic        csr_re = 1'b0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [7:0]  evt = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        hit_a, hit_b, irq_a, irq_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ama_riscv_hpm #(.NUM_CNT(6), .CNT_WIDTH(64), .NUM_EVT(8)) u_dut_a (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_re(csr_re), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .csr_rdata(rdata_a), .csr_hit(hit_a), .evt(evt), .ovf_irq(irq_a)
  );

  ama_riscv_hpm #(.NUM_CNT(2), .CNT_WIDTH(32), .NUM_EVT(8)) u_dut_b (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_re(csr_re), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .csr_rdata(rdata_b), .csr_hit(hit_b), .evt(evt), .ovf_irq(irq_b)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [7:0]  evt;
    int          ncyc;
    logic [11:0] raddr;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_hit;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic we, input logic [11:0] a, input logic [31:0] d,
                              input logic [7:0] e, input int n, input logic [11:0] ra,
                              input logic [31:0] ea, input logic [31:0] eb, input logic eh);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.evt = e; v.ncyc = n;
    v.raddr = ra; v.exp_a = ea; v.exp_b = eb; v.exp_hit = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] ea,
                    input logic [31:0] eb, input logic eh);
    csr_addr = a;
    csr_re   = 1'b1;
    #1;
    check({name, "_rdata_a"}, rdata_a, ea);
    check({name, "_rdata_b"}, rdata_b, eb);
    check({name, "_hit_a"}, 32'(hit_a), 32'(eh));
    check({name, "_hit_b"}, 32'(hit_b), 32'(eh));
    csr_re = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_addr  = a;
    csr_wdata = d;
    csr_we    = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check({name, "_irq_a"}, 32'(irq_a), 32'(exp));
    check({name, "_irq_b"}, 32'(irq_b), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   n;

    // Reset, map, basic count, inhibit, SEL edge cases, unimplemented slots, half writes
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'h320, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB03, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'h323, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'h321, 32'h0, 32'h0, 0));
    vq.push_back(mk(1, 12'h323, 32'h1, 8'h00, 1, 12'h323, 32'h1, 32'h1, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h01, 5, 12'hB03, 32'd5, 32'd5, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB04, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB83, 32'h0, 32'h0, 1));
    vq.push_back(mk(1, 12'h320, 32'h8, 8'h00, 1, 12'h320, 32'h8, 32'h8, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h01, 10, 12'hB03, 32'd5, 32'd5, 1));
    vq.push_back(mk(1, 12'h320, 32'h0, 8'h00, 1, 12'h320, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h01, 3, 12'hB03, 32'd8, 32'd8, 1));
    vq.push_back(mk(1, 12'h324, 32'h2, 8'h00, 1, 12'h324, 32'h2, 32'h2, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h02, 4, 12'hB04, 32'd4, 32'd4, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB03, 32'd8, 32'd8, 1));
    vq.push_back(mk(1, 12'h320, 32'hFFFF_FFFF, 8'h00, 1, 12'h320, 32'h1F8, 32'h18, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h03, 2, 12'hB03, 32'd8, 32'd8, 1));
    vq.push_back(mk(1, 12'h320, 32'h0, 8'h00, 1, 12'h320, 32'h0, 32'h0, 1));
    vq.push_back(mk(1, 12'h325, 32'h9, 8'h00, 1, 12'h325, 32'h9, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'hFF, 5, 12'hB05, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB03, 32'd13, 32'd13, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB04, 32'd9, 32'd9, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB06, 32'h0, 32'h0, 1));
    vq.push_back(mk(1, 12'h330, 32'hFFFF_FFFF, 8'h00, 1, 12'h330, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB10, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB90, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB09, 32'h0, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'h340, 32'h0, 32'h0, 0));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hBA0, 32'h0, 32'h0, 0));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'h31F, 32'h0, 32'h0, 0));
    vq.push_back(mk(1, 12'h324, 32'h7FFF_FF02, 8'h00, 1, 12'h324, 32'h2, 32'h2, 1));
    vq.push_back(mk(1, 12'hB84, 32'h1234_5678, 8'h00, 1, 12'hB84, 32'h1234_5678, 32'h0, 1));
    vq.push_back(mk(1, 12'hB04, 32'hAABB_CCDD, 8'h00, 1, 12'hB84, 32'h1234_5678, 32'h0, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h00, 0, 12'hB04, 32'hAABB_CCDD, 32'hAABB_CCDD, 1));
    vq.push_back(mk(0, 12'h000, 0, 8'h02, 1, 12'hB04, 32'hAABB_CCDE, 32'hAABB_CCDE, 1));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_irq("reset", 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      n = (v.we && v.ncyc == 0) ? 1 : v.ncyc;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        csr_we    = v.we && (c == 0);
        csr_addr  = v.addr;
        csr_wdata = v.wdata;
        evt       = v.evt;
      end
      if (n > 0) begin
        @(negedge clk);
        csr_we = 1'b0;
        evt    = '0;
      end
      rd($sformatf("vec%0d", i), v.raddr, v.exp_a, v.exp_b, v.exp_hit);
    end

    // Read enable low gates data even on a hit
    csr_addr = 12'hB04;
    csr_re   = 1'b0;
    #1;
    check("re_low_rdata_a", rdata_a, 32'h0);
    check("re_low_rdata_b", rdata_b, 32'h0);

    // Counter write collides with its own event: write wins
    @(negedge clk);
    csr_addr = 12'hB04; csr_wdata = 32'h100; csr_we = 1'b1; evt = 8'h02;
    @(negedge clk);
    csr_we = 1'b0; evt = '0;
    rd("collide_cnt", 12'hB04, 32'h100, 32'h100, 1);

    // Wrap from all-ones
    wr(12'hB83, 32'hFFFF_FFFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    rd("pre_wrap_lo", 12'hB03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    rd("pre_wrap_hi", 12'hB83, 32'hFFFF_FFFF, 32'h0, 1);
    chk_irq("pre_wrap", 1'b0);
    @(negedge clk);
    evt = 8'h01;
    @(negedge clk);
    evt = '0;
    chk_irq("post_wrap", OF_EN);
    rd("wrap_lo", 12'hB03, 32'h0, 32'h0, 1);
    rd("wrap_hi", 12'hB83, 32'h0, 32'h0, 1);
    rd("wrap_of", 12'h323, EVT3_WRAPPED, EVT3_WRAPPED, 1);
    wr(12'h323, 32'h1);
    rd("of_clear", 12'h323, 32'h1, 32'h1, 1);
    chk_irq("of_clear", 1'b0);

    // Event-register write clearing OF in the same cycle as an overflow
    wr(12'hB83, 32'hFFFF_FFFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    @(negedge clk);
    csr_addr = 12'h323; csr_wdata = 32'h1; csr_we = 1'b1; evt = 8'h01;
    @(negedge clk);
    csr_we = 1'b0; evt = '0;
    rd("collide_of", 12'h323, EVT3_WRAPPED, EVT3_WRAPPED, 1);
    rd("collide_of_cnt", 12'hB03, 32'h0, 32'h0, 1);
    chk_irq("collide_of", OF_EN);
    wr(12'h323, 32'h1);
    chk_irq("collide_of_clear", 1'b0);

    // Software may set OF directly
    wr(12'h323, 32'h8000_0001);
    rd("sw_of_set", 12'h323, EVT3_WRAPPED, EVT3_WRAPPED, 1);
    chk_irq("sw_of_set", OF_EN);
    wr(12'h323, 32'h1);

    // Reset mid-count, coincident with a counter write
    @(negedge clk);
    evt = 8'h03;
    repeat (3) @(negedge clk);
    rst = 1'b1; csr_addr = 12'hB03; csr_wdata = 32'h55; csr_we = 1'b1;
    @(negedge clk);
    rst = 1'b0; csr_we = 1'b0; evt = '0;
    rd("rst_cnt3", 12'hB03, 32'h0, 32'h0, 1);
    rd("rst_cnt4", 12'hB04, 32'h0, 32'h0, 1);
    rd("rst_evt3", 12'h323, 32'h0, 32'h0, 1);
    rd("rst_evt4", 12'h324, 32'h0, 32'h0, 1);
    rd("rst_inh", 12'h320, 32'h0, 32'h0, 1);
    chk_irq("rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
